ref_mem_ctrl_param: RTL and testbench
=====================================

# ref_mem_ctrl_param

Parametrised reference-frame memory controller for the integer motion-estimation (ME) array. It sits between the reference-pixel fetch unit and the banked reference SRAM feeding the processing-element (PE) array. It runs in three phases:
- Preload: fills the banks group by group, with valid/ready backpressure from the fetch side.
- Prime: issues the initial reads the PE pipeline needs.
- Search: sweeps the sub-area, shifting banks between row-tile offsets column by column, repeating one row per half-pass for data reuse, and stalling on PE backpressure.

## Interface
Parameters:
- NUM_BANKS, 32: number of single-port reference RAM banks.
- GROUP_BANKS, 4: banks written together per preload group; must divide NUM_BANKS.
- ADDR_W, 7: per-bank row address width.
- PRE_ROWS, 96: rows preloaded into each group; PRE_ROWS ≤ 2^ADDR_W.
- TILE_ROWS, 24: rows per half-pass; the row-tile offset unit.
- NUM_COLS, 7: column steps in the search phase.
- COL_SHIFT, 8: banks migrated to the next tile offset per column step.
- PRIME_ROWS, 4: read cycles in the prime phase.
- REUSE_ROW, 3: row index issued twice per half-pass; must be < TILE_ROWS.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: one-cycle request. Sampled only in IDLE.
- ref_valid, in, 1: the fetch unit presents one row for the current group.
- ref_ready, out, 1: controller accepts preload rows. Registered; high exactly while in PRELOAD.
- bank_we, out, NUM_BANKS: per-bank write enable. Combinational: ref_valid & ref_ready, masked to group g.
- wr_addr_all, out, NUM_BANKS*ADDR_W: write address. Bank b uses bits [b*ADDR_W +: ADDR_W]. Combinational; every field equals preload row r.
- pe_ready, in, 1: the PE array can accept a read beat.
- rd_en, out, 1: a read beat was issued this cycle. Registered.
- rd_addr_all, out, NUM_BANKS*ADDR_W: per-bank read address. Registered; bank layout as wr_addr_all.
- rd_col, out, 3 (ceil log2 NUM_COLS): column step of the current beat. Registered.
- rd_half, out, 1: 0 = upper sub-block pair, 1 = lower pair. Registered.
- rd_reuse, out, 1: the current beat repeats the previous row. Registered.
- busy, out, 1: high whenever the state is not IDLE. Registered.
- done, out, 1: one-cycle pulse when search completes. Registered.

## Operation
States: IDLE → PRELOAD → PRIME → SEARCH → DONE → IDLE.

IDLE
- All counters are cleared.
- When start=1, move to PRELOAD.

PRELOAD
- Counters: group g runs 0..NUM_BANKS/GROUP_BANKS−1; row r runs 0..PRE_ROWS−1.
- A beat is accepted when ref_valid & ref_ready.
- On each accepted beat:
  - bank_we asserts banks g*GROUP_BANKS .. g*GROUP_BANKS+GROUP_BANKS−1.
  - r increments. On wrap, r returns to 0 and g increments.
- No beat is accepted while ref_valid=0. All counters hold.
- After the last beat (g = last, r = PRE_ROWS−1), move to PRIME.

PRIME
- Issues PRIME_ROWS beats, p = 0..PRIME_ROWS−1.
- Every bank reads address p.
- Then move to SEARCH with c=0, h=0, row=0.

SEARCH
- Per-beat address for bank b:
  - k = c*COL_SHIFT, q = k / NUM_BANKS, m = k % NUM_BANKS.
  - addr_b = row + TILE_ROWS*(h + q + (b < m)).
  - Truncate the result to ADDR_W bits.
- Row sequence within a half-pass: rows 0..TILE_ROWS−1 ascending. Row REUSE_ROW is issued twice on consecutive beats, and rd_reuse=1 on the second.
- A half-pass is therefore TILE_ROWS+1 beats.
- After half h=0, set h=1. After h=1, set h=0 and increment c.
- After c=NUM_COLS−1, h=1, last row, move to DONE.

DONE
- done=1 for one cycle, then move to IDLE.

PE backpressure (PRIME and SEARCH)
- A beat is issued only on a cycle with pe_ready=1.
- When pe_ready=0: rd_en<=0, while rd_addr_all, rd_col, rd_half and all counters hold.

Configuration legality
- The parameter set must satisfy max addr_b < PRE_ROWS.
- The RTL does not check this. The bench asserts it at elaboration.

## Timing
- Reset values: ref_ready=0, bank_we=0, wr_addr_all=0, rd_en=0, rd_addr_all=0, rd_col=0, rd_half=0, rd_reuse=0, busy=0, done=0. The state is IDLE.
- start at edge N: busy=1 and ref_ready=1 from N+1.
- Write latency: zero. Data, bank_we and wr_addr_all align in the same cycle as ref_valid.
- Preload takes exactly NUM_BANKS/GROUP_BANKS*PRE_ROWS accepted beats (default 768).
- Read latency: rd_addr_all and rd_en appear one cycle after the issuing cycle. The first PRIME beat appears one cycle after PRELOAD ends.
- Total read beats (default): 4 + 7*2*25 = 354. done follows the last beat by one cycle. busy falls one cycle after done.
- start while busy: ignored.
- start in the same cycle as rst: ignored.
- rst at any point, mid-preload or mid-search: state returns to IDLE and all outputs return to reset values on the next edge. In-flight progress is discarded.
- pe_ready toggling every cycle: exactly one beat per high cycle. Beats are never skipped or duplicated, apart from the deliberate REUSE_ROW repeat.

## Test plan
- Default parameters, ref_valid and pe_ready held high:
  - Preload: 768 beats; group 0 writes bank_we=0x0000000F at r=0..95; the last beat is bank_we=0xF0000000, r=95.
  - Prime: reads 0..3.
  - Search: 350 beats; done asserts exactly 1 cycle after the last beat.
- Search address checks:
  - c=1, h=0, row=5: banks 0–7 read 29; banks 8–31 read 5.
  - c=6, h=1, row=23: banks 0–15 read 95; banks 16–31 read 71.
- Reuse: in every half-pass, row 3 is issued on two consecutive beats, and rd_reuse=1 only on the second.
- ref_valid low on every other cycle during preload: bank_we never asserts with ref_valid=0. Preload takes 1536 cycles and still covers all 768 rows.
- pe_ready held low for 10 cycles mid-search at c=2, h=1, row=10: rd_en=0 and addresses frozen throughout. Row 10 is issued once on release.
- rst asserted at preload beat 300, then start again: all outputs are 0 one cycle after rst, and preload restarts at g=0, r=0.
- Alternate configuration NUM_BANKS=16, GROUP_BANKS=2, COL_SHIFT=4: preload is 8 groups × 96 beats. At c=3, banks 0–11 receive the +TILE_ROWS offset.

Source files
------------

// File: rtl/ref_mem_ctrl_param.sv
// ref_mem_ctrl_param: banked reference-SRAM preload/prime/search controller feeding the ME PE array
module ref_mem_ctrl_param #(
  parameter int NUM_BANKS   = 32,
  parameter int GROUP_BANKS = 4,
  parameter int ADDR_W      = 7,
  parameter int PRE_ROWS    = 96,
  parameter int TILE_ROWS   = 24,
  parameter int NUM_COLS    = 7,
  parameter int COL_SHIFT   = 8,
  parameter int PRIME_ROWS  = 4,
  parameter int REUSE_ROW   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ref_valid,
  output logic                          ref_ready,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*ADDR_W-1:0]   wr_addr_all,
  input  logic                          pe_ready,
  output logic                          rd_en,
  output logic [NUM_BANKS*ADDR_W-1:0]   rd_addr_all,
  output logic [$clog2(NUM_COLS)-1:0]   rd_col,
  output logic                          rd_half,
  output logic                          rd_reuse,
  output logic                          busy,
  output logic                          done
);
  localparam int NG = NUM_BANKS / GROUP_BANKS;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int IW = $clog2(TILE_ROWS + 1);
  localparam int CW = $clog2(NUM_COLS);
  typedef enum logic [2:0] {IDLE, PRELOAD, PRIME, SEARCH, DONE} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [ADDR_W-1:0] r_q, r_d, p_q, p_d;
  logic [CW-1:0] c_q, c_d, rd_col_q, rd_col_d;
  logic [IW-1:0] i_q, i_d;
  logic h_q, h_d, rd_en_q, rd_en_d, rd_half_q, rd_half_d, rd_reuse_q, rd_reuse_d, done_q, done_d;
  logic [NUM_BANKS*ADDR_W-1:0] rd_addr_q, rd_addr_d, s_addr;
  logic [31:0] k_w, q_w, m_w, row_w;
  logic r_last, g_last, p_last, i_last, c_last;
  assign r_last = r_q == ADDR_W'(PRE_ROWS - 1);
  assign g_last = g_q == GW'(NG - 1);
  assign p_last = p_q == ADDR_W'(PRIME_ROWS - 1);
  assign i_last = i_q == IW'(TILE_ROWS);
  assign c_last = c_q == CW'(NUM_COLS - 1);
  always_comb begin
    k_w = 32'(c_q) * 32'(COL_SHIFT);
    q_w = k_w / 32'(NUM_BANKS);
    m_w = k_w % 32'(NUM_BANKS);
    row_w = (32'(i_q) > 32'(REUSE_ROW)) ? 32'(i_q) - 32'd1 : 32'(i_q);
    for (int b = 0; b < NUM_BANKS; b++)
      s_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(row_w + 32'(TILE_ROWS) * (32'(h_q) + q_w + ((32'(b) < m_w) ? 32'd1 : 32'd0)));
  end
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    r_d = r_q;
    p_d = p_q;
    c_d = c_q;
    h_d = h_q;
    i_d = i_q;
    rd_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_col_d = rd_col_q;
    rd_half_d = rd_half_q;
    rd_reuse_d = rd_reuse_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        g_d = '0;
        r_d = '0;
        p_d = '0;
        c_d = '0;
        h_d = 1'b0;
        i_d = '0;
        state_d = start ? PRELOAD : IDLE;
      end
      PRELOAD: if (ref_valid) begin
        r_d = r_last ? '0 : r_q + 1'b1;
        g_d = r_last ? g_q + 1'b1 : g_q;
        state_d = (r_last && g_last) ? PRIME : PRELOAD;
      end
      PRIME: if (pe_ready) begin
        rd_en_d = 1'b1;
        rd_addr_d = {NUM_BANKS{p_q}};
        rd_col_d = '0;
        rd_half_d = 1'b0;
        rd_reuse_d = 1'b0;
        p_d = p_q + 1'b1;
        state_d = p_last ? SEARCH : PRIME;
      end
      SEARCH: if (pe_ready) begin
        rd_en_d = 1'b1;
        rd_addr_d = s_addr;
        rd_col_d = c_q;
        rd_half_d = h_q;
        rd_reuse_d = i_q == IW'(REUSE_ROW + 1);
        i_d = i_last ? '0 : i_q + 1'b1;
        h_d = i_last ? ~h_q : h_q;
        c_d = (i_last && h_q) ? c_q + 1'b1 : c_q;
        state_d = (i_last && h_q && c_last) ? DONE : SEARCH;
      end
      DONE: begin
        done_d = !done_q;
        state_d = done_q ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      r_q <= '0;
      p_q <= '0;
      c_q <= '0;
      h_q <= 1'b0;
      i_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      rd_col_q <= '0;
      rd_half_q <= 1'b0;
      rd_reuse_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      r_q <= r_d;
      p_q <= p_d;
      c_q <= c_d;
      h_q <= h_d;
      i_q <= i_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_col_q <= rd_col_d;
      rd_half_q <= rd_half_d;
      rd_reuse_q <= rd_reuse_d;
      done_q <= done_d;
    end
  end
  assign ref_ready = state_q == PRELOAD;
  assign busy = state_q != IDLE;
  assign bank_we = (ref_valid && ref_ready) ? NUM_BANKS'({GROUP_BANKS{1'b1}}) << (32'(g_q) * 32'(GROUP_BANKS)) : '0;
  assign wr_addr_all = {NUM_BANKS{r_q}};
  assign rd_en = rd_en_q;
  assign rd_addr_all = rd_addr_q;
  assign rd_col = rd_col_q;
  assign rd_half = rd_half_q;
  assign rd_reuse = rd_reuse_q;
  assign done = done_q;
endmodule

// File: tb/tb_ref_mem_ctrl_param.sv
// tb_ref_mem_ctrl_param: directed stimulus with an arithmetic reference model for two parameter sets
module tb_ref_mem_ctrl_param;
  localparam int AW = 7, PR = 96, TR = 24, NC = 7, PRI = 4, RU = 3;
  localparam int NB = 32, GB = 4, CS = 8;
  localparam int NB2 = 16, GB2 = 2, CS2 = 4;
  localparam int TOTAL_RD = PRI + NC * 2 * (TR + 1);
  logic clk = 0, rst = 1, start = 0, start2 = 0, ref_valid = 0, pe_ready = 1;
  logic ref_ready, rd_en, rd_half, rd_reuse, busy, done;
  logic [NB-1:0] bank_we;
  logic [NB*AW-1:0] wr_addr_all, rd_addr_all;
  logic [2:0] rd_col;
  logic ref_ready2, rd_en2, rd_half2, rd_reuse2, busy2, done2;
  logic [NB2-1:0] bank_we2;
  logic [NB2*AW-1:0] wr_addr2, rd_addr2;
  logic [2:0] rd_col2;
  int passed = 0, total = 0;
  int n_wr[2], n_rd[2];
  bit last_prev[2], done_prev[2];
  always #5 clk = ~clk;
  ref_mem_ctrl_param u_dut (
    .clk(clk), .rst(rst), .start(start), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .bank_we(bank_we), .wr_addr_all(wr_addr_all), .pe_ready(pe_ready), .rd_en(rd_en),
    .rd_addr_all(rd_addr_all), .rd_col(rd_col), .rd_half(rd_half), .rd_reuse(rd_reuse),
    .busy(busy), .done(done)
  );
  ref_mem_ctrl_param #(.NUM_BANKS(NB2), .GROUP_BANKS(GB2), .COL_SHIFT(CS2)) u_alt (
    .clk(clk), .rst(rst), .start(start2), .ref_valid(ref_valid), .ref_ready(ref_ready2),
    .bank_we(bank_we2), .wr_addr_all(wr_addr2), .pe_ready(pe_ready), .rd_en(rd_en2),
    .rd_addr_all(rd_addr2), .rd_col(rd_col2), .rd_half(rd_half2), .rd_reuse(rd_reuse2),
    .busy(busy2), .done(done2)
  );
  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  function automatic logic [223:0] lit(input int nb, input int lo, input int lov, input int hiv);
    logic [223:0] v = '0;
    for (int b = 0; b < nb; b++) v[b*AW +: AW] = AW'(b < lo ? lov : hiv);
    return v;
  endfunction
  function automatic logic [31:0] gmask(input int gb, input int g);
    return 32'(((64'd1 << gb) - 64'd1) << (g * gb));
  endfunction
  function automatic int max_addr(input int nb, input int cs);
    int mx = 0;
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < nb; b++) begin
        int v = TR - 1 + TR * (1 + (c * cs) / nb + (b < (c * cs) % nb ? 1 : 0));
        if (v > mx) mx = v;
      end
    return mx;
  endfunction
  // Beat n of the read stream: prime rows first, then half-passes of TR+1 beats with REUSE_ROW doubled.
  task automatic exp_beat(input int nb, input int cs, input int n, output logic [223:0] a,
                          output int c, output int h, output bit reu);
    int s, j, row, k;
    a = '0;
    c = 0;
    h = 0;
    reu = 0;
    if (n < PRI) a = lit(nb, 0, n, n);
    else begin
      s = n - PRI;
      c = s / (2 * (TR + 1));
      h = (s / (TR + 1)) % 2;
      j = s % (TR + 1);
      row = j <= RU ? j : j - 1;
      reu = j == RU + 1;
      k = c * cs;
      for (int b = 0; b < nb; b++)
        a[b*AW +: AW] = AW'(row + TR * (h + k / nb + (b < k % nb ? 1 : 0)));
    end
  endtask
  task automatic cyc(input int id, input int nb, input int gb, input int cs, input logic rr,
                     input logic [31:0] we, input logic [223:0] wa, input logic re,
                     input logic [223:0] ra, input logic [2:0] col, input logic hf,
                     input logic ru, input logic dn, input logic bz);
    logic [223:0] ea;
    int c, h;
    bit reu, last_now;
    if (rr && ref_valid) begin
      chk("bank_we", 224'(we), 224'(n_wr[id] < nb / gb * PR ? gmask(gb, n_wr[id] / PR) : 32'd0));
      chk("wr_addr", wa, lit(nb, 0, n_wr[id] % PR, n_wr[id] % PR));
      if (id == 0 && n_wr[0] == 0) chk("we_first", 224'(we), 224'(32'h0000000F));
      if (id == 0 && n_wr[0] == 767) chk("we_last", 224'(we), 224'(32'hF0000000));
      if (id == 1 && n_wr[1] == 96) chk("alt_we_g1", 224'(we), 224'(32'h0000000C));
      n_wr[id]++;
    end else if (rr || ref_valid) chk("we_idle", 224'(we), 224'(0));
    last_now = 0;
    if (re) begin
      chk("rd_count", 224'(n_rd[id] < TOTAL_RD), 224'(1));
      exp_beat(nb, cs, n_rd[id], ea, c, h, reu);
      chk("rd_addr", ra, ea);
      chk("rd_col", 224'(col), 224'(c));
      chk("rd_half", 224'(hf), 224'(h));
      chk("rd_reuse", 224'(ru), 224'(reu));
      if (id == 0 && n_rd[0] == 60) chk("addr_c1h0r5", ra, lit(NB, 8, 29, 5));
      if (id == 0 && n_rd[0] == 353) chk("addr_c6h1r23", ra, lit(NB, 16, 95, 71));
      if (id == 0 && n_rd[0] == 140) chk("addr_c2h1r10", ra, lit(NB, 16, 58, 34));
      if (id == 0 && n_rd[0] == 7) chk("reuse_first", 224'({ru, ra}), 224'({1'b0, lit(NB, 0, 3, 3)}));
      if (id == 0 && n_rd[0] == 8) chk("reuse_second", 224'({ru, ra}), 224'({1'b1, lit(NB, 0, 3, 3)}));
      if (id == 1 && n_rd[1] == 154) chk("alt_addr_c3", ra, lit(NB2, 12, 24, 0));
      last_now = n_rd[id] == TOTAL_RD - 1;
      n_rd[id]++;
    end
    chk("done", 224'(dn), 224'(last_prev[id]));
    if (dn) chk("busy_at_done", 224'(bz), 224'(1));
    if (done_prev[id]) begin
      chk("busy_fall", 224'(bz), 224'(0));
      n_wr[id] = 0;
      n_rd[id] = 0;
    end
    last_prev[id] = last_now;
    done_prev[id] = dn;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      n_wr = '{0, 0};
      n_rd = '{0, 0};
      last_prev = '{0, 0};
      done_prev = '{0, 0};
    end else begin
      cyc(0, NB, GB, CS, ref_ready, 32'(bank_we), 224'(wr_addr_all), rd_en, 224'(rd_addr_all),
          rd_col, rd_half, rd_reuse, done, busy);
      cyc(1, NB2, GB2, CS2, ref_ready2, 32'(bank_we2), 224'(wr_addr2), rd_en2, 224'(rd_addr2),
          rd_col2, rd_half2, rd_reuse2, done2, busy2);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_ref_ready"}, 224'(ref_ready), 224'(0));
    chk({nm, "_bank_we"}, 224'(bank_we), 224'(0));
    chk({nm, "_wr_addr"}, 224'(wr_addr_all), 224'(0));
    chk({nm, "_rd_en"}, 224'(rd_en), 224'(0));
    chk({nm, "_rd_addr"}, 224'(rd_addr_all), 224'(0));
    chk({nm, "_rd_col"}, 224'(rd_col), 224'(0));
    chk({nm, "_rd_half"}, 224'(rd_half), 224'(0));
    chk({nm, "_rd_reuse"}, 224'(rd_reuse), 224'(0));
    chk({nm, "_busy"}, 224'(busy), 224'(0));
    chk({nm, "_done"}, 224'(done), 224'(0));
  endtask
  task automatic run_pre(input bit alt, input bit altv, output int n);
    if (alt) start2 = 1;
    else start = 1;
    tick();
    start = 0;
    start2 = 0;
    chk("busy_after_start", 224'(alt ? busy2 : busy), 224'(1));
    n = 0;
    while ((alt ? ref_ready2 : ref_ready) && n < 4000) begin
      ref_valid = altv ? n[0] : 1'b1;
      n++;
      tick();
    end
  endtask
  task automatic wait_idle(input bit alt);
    int k = 0;
    while ((alt ? busy2 : busy) && k < 2000) begin
      tick();
      k++;
    end
    chk("idle_timeout", 224'(alt ? busy2 : busy), 224'(0));
  endtask
  initial begin
    int n;
    logic [NB*AW-1:0] frozen;
    assert (max_addr(NB, CS) < PR && max_addr(NB2, CS2) < PR)
      else $fatal(1, "FAIL config: search addresses exceed preload rows");
    repeat (3) tick();
    chk_zero("reset");
    rst = 0;
    tick();
    run_pre(0, 0, n);
    chk("preload_cycles", 224'(n), 224'(768));
    chk("prime_latency0", 224'(rd_en), 224'(0));
    tick();
    chk("prime_first", 224'({rd_en, rd_addr_all}), 224'({1'b1, lit(NB, 0, 0, 0)}));
    repeat (199) tick();
    start = 1;
    tick();
    start = 0;
    wait_idle(0);
    run_pre(0, 1, n);
    chk("preload_cycles_alt_valid", 224'(n), 224'(1536));
    repeat (140) tick();
    pe_ready = 0;
    frozen = rd_addr_all;
    repeat (10) begin
      tick();
      chk("stall_rd_en", 224'(rd_en), 224'(0));
      chk("stall_addr", 224'(rd_addr_all), 224'(frozen));
    end
    pe_ready = 1;
    tick();
    chk("release_beat", 224'({rd_en, rd_addr_all}), 224'({1'b1, lit(NB, 16, 58, 34)}));
    wait_idle(0);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    chk("start_with_rst", 224'(busy), 224'(0));
    tick();
    chk("start_with_rst_idle", 224'(busy), 224'(0));
    ref_valid = 1;
    start = 1;
    tick();
    start = 0;
    repeat (300) tick();
    rst = 1;
    tick();
    rst = 0;
    chk_zero("mid_rst");
    run_pre(0, 0, n);
    chk("preload_restart_cycles", 224'(n), 224'(768));
    wait_idle(0);
    run_pre(1, 0, n);
    chk("alt_preload_cycles", 224'(n), 224'(768));
    wait_idle(1);
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
